// File: rtl/ycc_block_sequencer.sv
// Gathers a raster pixel stream into one BLK x BLK RGB block for the colour-convert/DCT core.
// Captures the core's Y/Cb/Cr buses PIPE_LAT cycles later and returns them over valid/ready.
module ycc_block_sequencer #(
   parameter int unsigned BLK      = 8,
   parameter int unsigned PIX_W    = 8,
   parameter int unsigned COEF_W   = 10,
   parameter int unsigned PIPE_LAT = 16,
   parameter int unsigned CNT_W    = 16
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [PIX_W-1:0]            in_r,
   input  logic [PIX_W-1:0]            in_g,
   input  logic [PIX_W-1:0]            in_b,
   output logic [BLK*BLK*PIX_W-1:0]    core_r,
   output logic [BLK*BLK*PIX_W-1:0]    core_g,
   output logic [BLK*BLK*PIX_W-1:0]    core_b,
   input  logic [BLK*BLK*COEF_W-1:0]   core_y,
   input  logic [BLK*BLK*COEF_W-1:0]   core_cb,
   input  logic [BLK*BLK*COEF_W-1:0]   core_cr,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [BLK*BLK*COEF_W-1:0]   out_y,
   output logic [BLK*BLK*COEF_W-1:0]   out_cb,
   output logic [BLK*BLK*COEF_W-1:0]   out_cr,
   output logic [CNT_W-1:0]            blk_count
);

   localparam int unsigned NPIX   = BLK * BLK;
   localparam int unsigned IDX_W  = (NPIX > 1) ? $clog2(NPIX) : 1;
   localparam int unsigned WAIT_W = $clog2(PIPE_LAT + 1);
   localparam int unsigned BUS_W  = NPIX * PIX_W;

   typedef enum logic [1:0] {
      S_FILL = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [IDX_W-1:0]    pix_idx;
   logic [WAIT_W-1:0]   wait_cnt;
   logic [BUS_W-1:0]    shadow_r;
   logic [BUS_W-1:0]    shadow_g;
   logic [BUS_W-1:0]    shadow_b;
   logic [BUS_W-1:0]    shadow_r_nxt;
   logic [BUS_W-1:0]    shadow_g_nxt;
   logic [BUS_W-1:0]    shadow_b_nxt;
   logic                pix_we;
   logic                load_core;
   logic                wait_inc;
   logic                capture;
   logic                deliver;

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_FILL;
      else        state <= state_nxt;
   end

   // Next-state and datapath control
   always_comb begin
      state_nxt = state;
      pix_we    = 1'b0;
      load_core = 1'b0;
      wait_inc  = 1'b0;
      capture   = 1'b0;
      deliver   = 1'b0;
      unique case (state)
         S_FILL: begin
            if (in_valid && in_ready) begin
               pix_we = 1'b1;
               if (pix_idx == IDX_W'(NPIX - 1)) begin
                  load_core = 1'b1;
                  state_nxt = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (wait_cnt == WAIT_W'(PIPE_LAT - 1)) begin
               capture   = 1'b1;
               state_nxt = S_HOLD;
            end else begin
               wait_inc = 1'b1;
            end
         end
         S_HOLD: begin
            if (out_ready) begin
               deliver   = 1'b1;
               state_nxt = S_FILL;
            end
         end
         default: state_nxt = S_FILL;
      endcase
   end

   // Shadow buffer with the incoming pixel merged in, so the last pixel reaches the core on its own edge
   always_comb begin
      shadow_r_nxt = shadow_r;
      shadow_g_nxt = shadow_g;
      shadow_b_nxt = shadow_b;
      shadow_r_nxt[32'(pix_idx) * PIX_W +: PIX_W] = in_r;
      shadow_g_nxt[32'(pix_idx) * PIX_W +: PIX_W] = in_g;
      shadow_b_nxt[32'(pix_idx) * PIX_W +: PIX_W] = in_b;
   end

   // Partial blocks are discarded by the index reset, so the buffer itself needs none
   always_ff @(posedge clk) begin
      if (pix_we) begin
         shadow_r <= shadow_r_nxt;
         shadow_g <= shadow_g_nxt;
         shadow_b <= shadow_b_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pix_idx   <= '0;
         wait_cnt  <= '0;
         in_ready  <= 1'b0;
         core_r    <= '0;
         core_g    <= '0;
         core_b    <= '0;
         out_valid <= 1'b0;
         out_y     <= '0;
         out_cb    <= '0;
         out_cr    <= '0;
         blk_count <= '0;
      end else begin
         in_ready <= (state_nxt == S_FILL);
         if (pix_we) pix_idx <= load_core ? '0 : pix_idx + IDX_W'(1);
         if (load_core) begin
            wait_cnt <= '0;
            core_r   <= shadow_r_nxt;
            core_g   <= shadow_g_nxt;
            core_b   <= shadow_b_nxt;
         end else if (wait_inc) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
         end
         if (capture) begin
            out_valid <= 1'b1;
            out_y     <= core_y;
            out_cb    <= core_cb;
            out_cr    <= core_cr;
         end else if (deliver) begin
            out_valid <= 1'b0;
            blk_count <= blk_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_ycc_block_sequencer.sv
// Directed bench for ycc_block_sequencer: ordering, capture latency, backpressure,
// gapped input, mid-block reset and block-counter wrap (CNT_W=2).
module tb_ycc_block_sequencer;

   localparam int unsigned BLK      = 8;
   localparam int unsigned PIX_W    = 8;
   localparam int unsigned COEF_W   = 10;
   localparam int unsigned PIPE_LAT = 16;
   localparam int unsigned CNT_W    = 2;
   localparam int unsigned NPIX     = BLK * BLK;

   logic                       clk = 1'b0;
   logic                       reset;
   logic                       in_valid;
   logic                       in_ready;
   logic [PIX_W-1:0]           in_r, in_g, in_b;
   logic [NPIX*PIX_W-1:0]      core_r, core_g, core_b;
   logic [NPIX*COEF_W-1:0]     core_y, core_cb, core_cr;
   logic                       out_valid;
   logic                       out_ready;
   logic [NPIX*COEF_W-1:0]     out_y, out_cb, out_cr;
   logic [CNT_W-1:0]           blk_count;

   logic                       echo;
   logic [COEF_W-1:0]          man_y;
   int                         n_chk = 0;
   int                         n_pass = 0;

   always #5 clk = ~clk;

   ycc_block_sequencer #(
      .BLK(BLK), .PIX_W(PIX_W), .COEF_W(COEF_W), .PIPE_LAT(PIPE_LAT), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_r(in_r), .in_g(in_g), .in_b(in_b),
      .core_r(core_r), .core_g(core_g), .core_b(core_b),
      .core_y(core_y), .core_cb(core_cb), .core_cr(core_cr),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_y(out_y), .out_cb(out_cb), .out_cr(out_cr),
      .blk_count(blk_count)
   );

   // Core model: echoes sample k into coefficient lane k, or drives a fixed Y value in every lane
   always_comb begin
      core_y  = '0;
      core_cb = '0;
      core_cr = '0;
      for (int k = 0; k < NPIX; k++) begin
         core_y[k*COEF_W +: COEF_W]  = echo ? COEF_W'(core_r[k*PIX_W +: PIX_W]) : man_y;
         core_cb[k*COEF_W +: COEF_W] = COEF_W'(core_g[k*PIX_W +: PIX_W]);
         core_cr[k*COEF_W +: COEF_W] = COEF_W'(core_b[k*PIX_W +: PIX_W]);
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one pixel and return just after the edge that accepted it
   task automatic send_pix(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_r = r;
      in_g = g;
      in_b = b;
      while (!in_ready && n < 200) begin
         tick();
         n++;
      end
      if (n >= 200) chk("in_ready_timeout", 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_out_valid();
      int n;
      n = 0;
      while (!out_valid && n < 100) begin
         tick();
         n++;
      end
      chk("out_valid_wait", 64'(out_valid), 64'd1);
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   logic [CNT_W-1:0] exp_cnt [5];
   logic             ready_leak;

   initial begin
      exp_cnt    = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      reset      = 1'b0;
      in_valid   = 1'b1;
      in_r       = 8'h11;
      in_g       = 8'h22;
      in_b       = 8'h33;
      out_ready  = 1'b0;
      echo       = 1'b1;
      man_y      = '0;
      ready_leak = 1'b0;

      // Reset held with in_valid asserted
      repeat (5) tick();
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_core_r", core_r[63:0], 64'd0);
      chk("rst_blk_count", 64'(blk_count), 64'd0);
      chk("rst_out_y", out_y[63:0], 64'd0);
      in_valid = 1'b0;
      reset = 1'b1;
      chk("rel_in_ready_pre", 64'(in_ready), 64'd0);
      tick();
      chk("rel_in_ready_post", 64'(in_ready), 64'd1);

      // Ordering and latency: R=k, G=2k, B=255-k
      for (int k = 0; k < 64; k++) send_pix(8'(k), 8'(2 * k), 8'(255 - k));
      chk("ord_in_ready_wait", 64'(in_ready), 64'd0);
      chk("ord_core_r_lane0", 64'(core_r[7:0]), 64'd0);
      chk("ord_core_r_lane63", 64'(core_r[511:504]), 64'd63);
      chk("ord_core_g_lane63", 64'(core_g[511:504]), 64'd126);
      chk("ord_core_b_lane63", 64'(core_b[511:504]), 64'd192);
      repeat (PIPE_LAT - 1) tick();
      chk("lat_out_valid_T15", 64'(out_valid), 64'd0);
      tick();
      chk("lat_out_valid_T16", 64'(out_valid), 64'd1);
      chk("ord_out_y_lane63", 64'(out_y[63*COEF_W +: COEF_W]), 64'd63);
      chk("ord_out_cb_lane63", 64'(out_cb[63*COEF_W +: COEF_W]), 64'd126);
      chk("ord_out_cr_lane5", 64'(out_cr[5*COEF_W +: COEF_W]), 64'd250);
      handshake();
      chk("blk1_out_valid", 64'(out_valid), 64'd0);
      chk("blk1_count", 64'(blk_count), 64'd1);
      chk("blk1_in_ready", 64'(in_ready), 64'd1);

      // Gapped input: in_valid toggles 1/0, R = k ^ 0x5A
      echo = 1'b0;
      man_y = 10'h0AA;
      for (int k = 0; k < 64; k++) begin
         send_pix(8'(k) ^ 8'h5A, 8'(k), 8'(k));
         if (k == 62) chk("gap_63_not_full", 64'(in_ready), 64'd1);
         if (k != 63) tick();
      end
      chk("gap_full_in_ready", 64'(in_ready), 64'd0);
      chk("gap_core_r_lane0", 64'(core_r[7:0]), 64'h5A);
      chk("gap_core_r_lane31", 64'(core_r[31*8 +: 8]), 64'h45);
      chk("gap_core_r_lane63", 64'(core_r[511:504]), 64'h65);

      // Capture edge: core output changes after T+15 and again after T+16
      repeat (PIPE_LAT - 2) tick();
      man_y = 10'h155;
      tick();
      chk("cap_out_valid_T15", 64'(out_valid), 64'd0);
      man_y = 10'h2A3;
      tick();
      chk("cap_out_valid_T16", 64'(out_valid), 64'd1);
      man_y = 10'h3C7;
      chk("cap_out_y_lane0", 64'(out_y[9:0]), 64'h2A3);
      chk("cap_out_y_lane63", 64'(out_y[63*COEF_W +: COEF_W]), 64'h2A3);

      // Backpressure: hold out_ready low 40 cycles with a pixel offered
      in_valid = 1'b1;
      in_r = 8'hEE;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (in_ready) ready_leak = 1'b1;
      end
      chk("bp_in_ready_low", 64'(ready_leak), 64'd0);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_out_y_stable", 64'(out_y[9:0]), 64'h2A3);
      chk("bp_core_r_stable", 64'(core_r[7:0]), 64'h5A);
      chk("bp_blk_count", 64'(blk_count), 64'd1);
      handshake();
      in_valid = 1'b0;
      chk("bp_rel_blk_count", 64'(blk_count), 64'd2);
      chk("bp_rel_out_valid", 64'(out_valid), 64'd0);
      chk("bp_rel_in_ready", 64'(in_ready), 64'd1);
      chk("bp_rel_core_r", 64'(core_r[7:0]), 64'h5A);

      // Mid-block reset after pixel 30
      echo = 1'b1;
      for (int k = 0; k <= 30; k++) send_pix(8'hC0 | 8'(k), 8'h00, 8'h00);
      reset = 1'b0;
      tick();
      chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
      chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
      chk("mid_rst_core_r", core_r[63:0], 64'd0);
      chk("mid_rst_blk_count", 64'(blk_count), 64'd0);
      reset = 1'b1;
      tick();

      // Five full blocks after reset; first checks restart at k=0, all check counter wrap
      for (int b = 0; b < 5; b++) begin
         for (int k = 0; k < 64; k++) send_pix(8'(k + 1 + b), 8'(k), 8'(k));
         if (b == 0) begin
            chk("mid_core_r_lane0", 64'(core_r[7:0]), 64'd1);
            chk("mid_core_r_lane63", 64'(core_r[511:504]), 64'd64);
         end
         wait_out_valid();
         if (b == 0) chk("mid_out_y_lane0", 64'(out_y[9:0]), 64'd1);
         handshake();
         chk($sformatf("wrap_blk_count_%0d", b), 64'(blk_count), 64'(exp_cnt[b]));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
